// File: rtl/fpdiv.sv
// ---------------------------------------------------------------------------
// fpdiv : Goldschmidt-iteration mantissa divider datapath.
//
// Purpose
//   Divides the 24-bit significands of two single-precision operands using
//   repeated multiplication by a correction factor.  A single 27x27 multiplier
//   is shared by all steps.  The block contains no sequencer; an external
//   controller drives the operand selects and the register load enables.
//   The working format is Q1.26 (1 integer bit, 26 fraction bits).
//
// Ports
//   inputNum   [31:0] in  numerator, only fraction bits [22:0] are used
//   inputDenom [31:0] in  denominator, only fraction bits [22:0] are used
//   clk               in  clock, rising edge
//   reset             in  synchronous active-high clear of A, B, C, rrem
//   en_a              in  load A from the truncated product
//   en_b              in  load B from the truncated product, C from 2 - product
//   en_rem            in  load rrem with Nm - truncated product
//   out        [53:0] out combinational full product X*Y (Q2.52)
//   tb_rega    [26:0] out register A (running quotient)
//   tb_regb    [26:0] out register B (running denominator)
//   tb_regc    [26:0] out register C (correction factor)
//   sel_mux3   [1:0]  in  operand Y: 00 IA, 01 C, 10 Dm, 11 zero
//   sel_mux4   [1:0]  in  operand X: 00 Nm, 01 Dm, 10 A, 11 B
//   rrem       [26:0] out remainder, two's complement Q1.26
// ---------------------------------------------------------------------------
module fpdiv (
    input  logic [31:0] inputNum,
    input  logic [31:0] inputDenom,
    input  logic        clk,
    input  logic        reset,
    input  logic        en_a,
    input  logic        en_b,
    input  logic        en_rem,
    output logic [53:0] out,
    output logic [26:0] tb_rega,
    output logic [26:0] tb_regb,
    output logic [26:0] tb_regc,
    input  logic [1:0]  sel_mux3,
    input  logic [1:0]  sel_mux4,
    output logic [26:0] rrem
);

    // Two's complement negation in 27 bits.  2.0 in Q1.26 is 2^27, which
    // wraps to zero, so negating P yields 2.0 - P directly.
    function automatic logic [26:0] two_minus(input logic [26:0] val);
        return ~val + 27'd1;
    endfunction

    // Initial reciprocal seed: v = floor(8192 / (33 + 2i)), i.e. an 8-bit
    // approximation of 1/D taken at the midpoint of each 1/16 interval.
    function automatic logic [7:0] recip_seed(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'd248;
            4'd1:    return 8'd234;
            4'd2:    return 8'd221;
            4'd3:    return 8'd210;
            4'd4:    return 8'd199;
            4'd5:    return 8'd190;
            4'd6:    return 8'd182;
            4'd7:    return 8'd174;
            4'd8:    return 8'd167;
            4'd9:    return 8'd160;
            4'd10:   return 8'd154;
            4'd11:   return 8'd148;
            4'd12:   return 8'd143;
            4'd13:   return 8'd138;
            4'd14:   return 8'd134;
            default: return 8'd130;
        endcase
    endfunction

    logic [26:0] nm;
    logic [26:0] dm;
    logic [26:0] ia;
    logic [26:0] op_x;
    logic [26:0] op_y;
    logic [26:0] prod_t;
    logic        unused_exp_bits;

    logic [26:0] a_q, a_d;
    logic [26:0] b_q, b_d;
    logic [26:0] c_q, c_d;
    logic [26:0] rem_q, rem_d;

    // Sign and exponent fields are handled outside this datapath.
    assign unused_exp_bits = ^{inputNum[31:23], inputDenom[31:23]};

    assign nm = {1'b1, inputNum[22:0], 3'b000};
    assign dm = {1'b1, inputDenom[22:0], 3'b000};
    assign ia = {1'b0, recip_seed(inputDenom[22:19]), 18'd0};

    always_comb begin
        op_x = b_q;
        case (sel_mux4)
            2'b00:   op_x = nm;
            2'b01:   op_x = dm;
            2'b10:   op_x = a_q;
            default: op_x = b_q;
        endcase
    end

    always_comb begin
        op_y = 27'd0;
        case (sel_mux3)
            2'b00:   op_y = ia;
            2'b01:   op_y = c_q;
            2'b10:   op_y = dm;
            default: op_y = 27'd0;
        endcase
    end

    assign out = {27'd0, op_x} * {27'd0, op_y};

    // Back to Q1.26 by truncation; bit 53 can only be set by out-of-range
    // operands and is discarded.
    assign prod_t = out[52:26];

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        rem_d = rem_q;
        if (en_a) begin
            a_d = prod_t;
        end
        if (en_b) begin
            b_d = prod_t;
            c_d = two_minus(prod_t);
        end
        if (en_rem) begin
            rem_d = nm - prod_t;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q   <= 27'd0;
            b_q   <= 27'd0;
            c_q   <= 27'd0;
            rem_q <= 27'd0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            rem_q <= rem_d;
        end
    end

    assign tb_rega = a_q;
    assign tb_regb = b_q;
    assign tb_regc = c_q;
    assign rrem    = rem_q;

endmodule

// File: tb/tb_fpdiv.sv
// ---------------------------------------------------------------------------
// tb_fpdiv : directed self-checking bench for the fpdiv datapath.
// ---------------------------------------------------------------------------
module tb_fpdiv;

    logic [31:0] inputNum;
    logic [31:0] inputDenom;
    logic        clk;
    logic        reset;
    logic        en_a;
    logic        en_b;
    logic        en_rem;
    logic [53:0] out;
    logic [26:0] tb_rega;
    logic [26:0] tb_regb;
    logic [26:0] tb_regc;
    logic [1:0]  sel_mux3;
    logic [1:0]  sel_mux4;
    logic [26:0] rrem;

    int n_vec = 0;
    int n_err = 0;

    // Reference state of A, B, C, rrem.
    logic [26:0] m_a, m_b, m_c, m_r;

    fpdiv dut (
        .inputNum   (inputNum),
        .inputDenom (inputDenom),
        .clk        (clk),
        .reset      (reset),
        .en_a       (en_a),
        .en_b       (en_b),
        .en_rem     (en_rem),
        .out        (out),
        .tb_rega    (tb_rega),
        .tb_regb    (tb_regb),
        .tb_regc    (tb_regc),
        .sel_mux3   (sel_mux3),
        .sel_mux4   (sel_mux4),
        .rrem       (rrem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [26:0] mant(input logic [31:0] f);
        return {1'b1, f[22:0], 3'b000};
    endfunction

    function automatic logic [26:0] seed(input logic [31:0] f);
        int idx;
        int v;
        idx = int'(f[22:19]);
        v   = 8192 / (33 + 2 * idx);
        return 27'(v) << 18;
    endfunction

    function automatic logic [26:0] pick_x(input logic [1:0] s);
        case (s)
            2'b00:   return mant(inputNum);
            2'b01:   return mant(inputDenom);
            2'b10:   return m_a;
            default: return m_b;
        endcase
    endfunction

    function automatic logic [26:0] pick_y(input logic [1:0] s);
        case (s)
            2'b00:   return seed(inputDenom);
            2'b01:   return m_c;
            2'b10:   return mant(inputDenom);
            default: return 27'd0;
        endcase
    endfunction

    task automatic chk_regs(input string tag);
        chk({tag, "_a"}, 64'(tb_rega), 64'(m_a));
        chk({tag, "_b"}, 64'(tb_regb), 64'(m_b));
        chk({tag, "_c"}, 64'(tb_regc), 64'(m_c));
        chk({tag, "_r"}, 64'(rrem),    64'(m_r));
    endtask

    // One clocked step: drive controls, check the combinational product,
    // then check all registers after the edge.
    task automatic step(input string tag, input logic [1:0] m4, input logic [1:0] m3,
                        input logic ea, input logic eb, input logic er);
        logic [53:0] prod;
        logic [26:0] p;
        @(negedge clk);
        reset    = 1'b0;
        sel_mux4 = m4;
        sel_mux3 = m3;
        en_a     = ea;
        en_b     = eb;
        en_rem   = er;
        #1;
        prod = 54'(64'(pick_x(m4)) * 64'(pick_y(m3)));
        chk({tag, "_out"}, 64'(out), 64'(prod));
        p = prod[52:26];
        @(posedge clk);
        #1;
        if (ea) m_a = p;
        if (eb) begin
            m_b = p;
            m_c = 27'(28'h800_0000 - {1'b0, p});
        end
        if (er) m_r = mant(inputNum) - p;
        chk_regs(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset  = 1'b1;
        en_a   = 1'b1;
        en_b   = 1'b1;
        en_rem = 1'b1;
        @(posedge clk);
        #1;
        m_a = '0; m_b = '0; m_c = '0; m_r = '0;
        chk({tag, "_a"}, 64'(tb_rega), 64'd0);
        chk({tag, "_b"}, 64'(tb_regb), 64'd0);
        chk({tag, "_c"}, 64'(tb_regc), 64'd0);
        chk({tag, "_r"}, 64'(rrem),    64'd0);
        @(negedge clk);
        reset  = 1'b0;
        en_a   = 1'b0;
        en_b   = 1'b0;
        en_rem = 1'b0;
    endtask

    initial begin
        logic [63:0] q_ref;
        logic [63:0] diff;
        int          rsig;

        reset = 1'b1; en_a = 1'b0; en_b = 1'b0; en_rem = 1'b0;
        sel_mux3 = 2'b00; sel_mux4 = 2'b00;
        // Upper bits are junk on purpose; the datapath must ignore them.
        inputNum   = 32'hFF80_0000;
        inputDenom = 32'h7F80_0000;
        m_a = '0; m_b = '0; m_c = '0; m_r = '0;

        do_reset("rst_init");

        // ---- N = D = 1.0 --------------------------------------------------
        step("one_s1", 2'b10 ^ 2'b10, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("one_s1_const_a", 64'(tb_rega), 64'h3E0_0000);
        step("one_s2", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        chk("one_s2_const_b", 64'(tb_regb), 64'h3E0_0000);
        chk("one_s2_const_c", 64'(tb_regc), 64'h420_0000);
        step("one_i1a", 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
        step("one_i1b", 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        chk("one_i1_const_a", 64'(tb_rega), 64'h3FF_0000);
        chk("one_i1_const_b", 64'(tb_regb), 64'h3FF_0000);
        chk("one_i1_const_c", 64'(tb_regc), 64'h401_0000);
        step("one_i2a", 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
        step("one_i2b", 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        chk("one_i2_const_a", 64'(tb_rega), 64'h3FF_FFC0);
        chk("one_i2_const_b", 64'(tb_regb), 64'h3FF_FFC0);
        step("one_i3a", 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
        step("one_i3b", 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        chk("one_i3_const_a", 64'(tb_rega), 64'h3FF_FFFF);
        chk("one_i3_const_b", 64'(tb_regb), 64'h3FF_FFFF);
        @(negedge clk);
        sel_mux4 = 2'b10; sel_mux3 = 2'b10;
        #1;
        chk("one_rem_const_out", 64'(out), 64'hF_FFFF_FC00_0000);
        step("one_rem", 2'b10, 2'b10, 1'b0, 1'b0, 1'b1);
        chk("one_rem_const_r", 64'(rrem), 64'h000_0001);

        // ---- Hold: selects toggle, nothing loads --------------------------
        step("hold0", 2'b00, 2'b11, 1'b0, 1'b0, 1'b0);
        step("hold1", 2'b11, 2'b10, 1'b0, 1'b0, 1'b0);
        step("hold2", 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("hold_const_a", 64'(tb_rega), 64'h3FF_FFFF);
        chk("hold_const_r", 64'(rrem), 64'h000_0001);

        // ---- All enables together load from the same product --------------
        step("all_en", 2'b11, 2'b01, 1'b1, 1'b1, 1'b1);

        // ---- Reset mid-iteration has priority over enables ----------------
        do_reset("rst_mid");

        // ---- Top ROM entry (i = 15) ---------------------------------------
        inputDenom = 32'h007F_FFFF;
        step("rom15", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);

        // ---- Nm fraction 0x513C8A / Dm fraction 0x1E2585 -------------------
        inputNum   = 32'h3FD1_3C8A;
        inputDenom = 32'hC01E_2585;
        step("q_s1", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        step("q_s2", 2'b01, 2'b00, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step($sformatf("q_i%0da", k), 2'b10, 2'b01, 1'b1, 1'b0, 1'b0);
            step($sformatf("q_i%0db", k), 2'b11, 2'b01, 1'b0, 1'b1, 1'b0);
        end
        step("q_rem", 2'b10, 2'b10, 1'b0, 1'b0, 1'b1);

        q_ref = {11'd0, mant(inputNum), 26'd0} / {37'd0, mant(inputDenom)};
        diff  = (64'(tb_rega) > q_ref) ? 64'(tb_rega) - q_ref : q_ref - 64'(tb_rega);
        chk("q_quot_close", 64'(diff <= 64'd16), 64'd1);
        chk("q_b_near_one", 64'((tb_regb == 27'h3FF_FFFF) || (tb_regb == 27'h400_0000)), 64'd1);
        rsig = int'($signed(rrem));
        chk("q_rem_small", 64'((rsig <= 32) && (rsig >= -32)), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
